// File: rtl/rooth_int_pkg.sv
// Shared constants for the rooth interrupt controller: source count, register map, FSM states.
// Build option: define ROOTH_INT_EDGE_EN for rising-edge request capture (see rooth_int_ctrl).
package rooth_int_pkg;

    localparam int RI_INT_NUM   = 8;
    localparam int RI_ADDR_W    = 4;
    localparam int RI_CPU_WIDTH = 32;

    localparam logic [RI_ADDR_W-1:0] INT_PEND_ADDR  = 4'h0;
    localparam logic [RI_ADDR_W-1:0] INT_MASK_ADDR  = 4'h4;
    localparam logic [RI_ADDR_W-1:0] INT_CLAIM_ADDR = 4'h8;

    typedef enum logic [1:0] {
        INT_IDLE    = 2'd0,
        INT_REQ     = 2'd1,
        INT_SERVICE = 2'd2
    } int_state_e;

endpackage

// File: rtl/rooth_int_prio.sv
// Fixed-priority encoder: the lowest set index of eligible wins.
module rooth_int_prio
    import rooth_int_pkg::*;
#(
    parameter int N   = RI_INT_NUM,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   eligible,
    output logic           any,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] id
);

    // Scan from the top down so the lowest index is the last to overwrite.
    always_comb begin
        any    = |eligible;
        onehot = '0;
        id     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                id        = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/rooth_int_ctrl.sv
// Interrupt controller feeding the rooth core int_flag_i: pending/mask registers, priority grant, req/ack/done.
// Build option: ROOTH_INT_EDGE_EN selects rising-edge capture of irq_src_i instead of level capture.
module rooth_int_ctrl
    import rooth_int_pkg::*;
#(
    parameter int INT_NUM   = RI_INT_NUM,
    parameter int ADDR_W    = RI_ADDR_W,
    parameter int CPU_WIDTH = RI_CPU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INT_NUM-1:0]   irq_src_i,
    input  logic                 bus_wr_en_i,
    input  logic                 bus_rd_en_i,
    input  logic [ADDR_W-1:0]    bus_addr_i,
    input  logic [CPU_WIDTH-1:0] bus_wdata_i,
    output logic [CPU_WIDTH-1:0] bus_rdata_o,
    output logic                 int_req_o,
    output logic [INT_NUM-1:0]   int_flag_o,
    input  logic                 int_ack_i,
    input  logic                 int_done_i
);

    localparam int IDW = $clog2(INT_NUM);

    int_state_e           state_q, state_d;
    logic [INT_NUM-1:0]   pend_q, pend_d, mask_q, mask_d;
    logic [INT_NUM-1:0]   flag_d, set_vec, clr_vec;
    logic [INT_NUM-1:0]   eligible, eligible_nxt, win_onehot;
    logic [IDW-1:0]       win_id, flag_id, claim_q, claim_d;
    logic                 win_any, req_d, wr_pend, wr_mask, ack_hit;
    logic [CPU_WIDTH-1:0] rd_word;
    logic                 unused_flag_any;
    logic [INT_NUM-1:0]   unused_flag_onehot;
    logic                 unused_wdata;

    assign unused_wdata = ^bus_wdata_i[CPU_WIDTH-1:INT_NUM];

`ifdef ROOTH_INT_EDGE_EN
    logic [INT_NUM-1:0] src_p0, src_p1;

    // Stage p0 registers the raw line, p1 delays it once more for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_p0 <= '0;
            src_p1 <= '0;
        end else begin
            src_p0 <= irq_src_i;
            src_p1 <= src_p0;
        end
    end

    assign set_vec = src_p0 & ~src_p1;
`else
    assign set_vec = irq_src_i;
`endif

    assign wr_pend = bus_wr_en_i && (bus_addr_i == ADDR_W'(INT_PEND_ADDR));
    assign wr_mask = bus_wr_en_i && (bus_addr_i == ADDR_W'(INT_MASK_ADDR));
    assign ack_hit = (state_q == INT_REQ) && int_ack_i;

    // Set is OR-ed in after the clear so a same-cycle request always survives.
    assign clr_vec      = (wr_pend ? bus_wdata_i[INT_NUM-1:0] : '0) | (ack_hit ? int_flag_o : '0);
    assign pend_d       = (pend_q & ~clr_vec) | set_vec;
    assign mask_d       = wr_mask ? bus_wdata_i[INT_NUM-1:0] : mask_q;
    assign eligible     = pend_q & mask_q;
    assign eligible_nxt = pend_d & mask_d;

    rooth_int_prio #(.N(INT_NUM), .IDW(IDW)) u_prio_win (
        .eligible (eligible),
        .any      (win_any),
        .onehot   (win_onehot),
        .id       (win_id)
    );

    rooth_int_prio #(.N(INT_NUM), .IDW(IDW)) u_prio_flag (
        .eligible (int_flag_o),
        .any      (unused_flag_any),
        .onehot   (unused_flag_onehot),
        .id       (flag_id)
    );

    always_comb begin
        state_d = state_q;
        req_d   = int_req_o;
        flag_d  = int_flag_o;
        claim_d = claim_q;
        case (state_q)
            INT_IDLE: begin
                if (win_any) begin
                    state_d = INT_REQ;
                    req_d   = 1'b1;
                    flag_d  = win_onehot;
                end
            end
            INT_REQ: begin
                // Ack takes precedence; otherwise withdraw once the granted source stops being eligible.
                if (int_ack_i) begin
                    state_d = INT_SERVICE;
                    req_d   = 1'b0;
                    flag_d  = '0;
                    claim_d = flag_id;
                end else if ((int_flag_o & eligible_nxt) == '0) begin
                    state_d = INT_IDLE;
                    req_d   = 1'b0;
                    flag_d  = '0;
                end
            end
            INT_SERVICE: begin
                if (int_done_i) state_d = INT_IDLE;
            end
            default: begin
                state_d = INT_IDLE;
                req_d   = 1'b0;
                flag_d  = '0;
            end
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (bus_addr_i == ADDR_W'(INT_PEND_ADDR)) begin
            rd_word[INT_NUM-1:0] = pend_q;
        end else if (bus_addr_i == ADDR_W'(INT_MASK_ADDR)) begin
            rd_word[INT_NUM-1:0] = mask_q;
        end else if (bus_addr_i == ADDR_W'(INT_CLAIM_ADDR)) begin
            rd_word[8]       = (state_q == INT_SERVICE);
            rd_word[IDW-1:0] = claim_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= INT_IDLE;
            pend_q      <= '0;
            mask_q      <= '0;
            claim_q     <= '0;
            int_req_o   <= 1'b0;
            int_flag_o  <= '0;
            bus_rdata_o <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            claim_q    <= claim_d;
            int_req_o  <= req_d;
            int_flag_o <= flag_d;
            if (bus_rd_en_i) bus_rdata_o <= rd_word;
        end
    end

endmodule

// File: tb/tb_rooth_int_ctrl.sv
// Bench for rooth_int_ctrl: directed handshake scenarios plus random traffic against a behavioural model.
module tb_rooth_int_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_src_i;
    logic        bus_wr_en_i, bus_rd_en_i;
    logic [3:0]  bus_addr_i;
    logic [31:0] bus_wdata_i;
    logic [31:0] bus_rdata_o;
    logic        int_req_o;
    logic [7:0]  int_flag_o;
    logic        int_ack_i, int_done_i;

    int vectors     = 0;
    int miscompares = 0;

    // Model: pending/mask bytes, granted source (-1 = none), service flag, last claim, read register.
    logic [7:0]  m_pend, m_mask;
    int          m_req_src;
    bit          m_serving;
    int          m_claim;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    rooth_int_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_src_i   (irq_src_i),
        .bus_wr_en_i (bus_wr_en_i),
        .bus_rd_en_i (bus_rd_en_i),
        .bus_addr_i  (bus_addr_i),
        .bus_wdata_i (bus_wdata_i),
        .bus_rdata_o (bus_rdata_o),
        .int_req_o   (int_req_o),
        .int_flag_o  (int_flag_o),
        .int_ack_i   (int_ack_i),
        .int_done_i  (int_done_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] w1c, ack_clr, np, nm;
        if (!rst_n) begin
            m_pend = 8'h0; m_mask = 8'h0; m_req_src = -1;
            m_serving = 1'b0; m_claim = 0; m_rdata = 32'h0;
            return;
        end
        w1c     = (bus_wr_en_i && bus_addr_i == 4'h0) ? bus_wdata_i[7:0] : 8'h0;
        ack_clr = (m_req_src >= 0 && int_ack_i) ? 8'(1 << m_req_src) : 8'h0;
        np = m_pend;
        for (int i = 0; i < 8; i++) begin
            if (irq_src_i[i]) np[i] = 1'b1;
            else if (w1c[i] || ack_clr[i]) np[i] = 1'b0;
        end
        nm = (bus_wr_en_i && bus_addr_i == 4'h4) ? bus_wdata_i[7:0] : m_mask;
        if (bus_rd_en_i) begin
            case (bus_addr_i)
                4'h0:    m_rdata = {24'h0, m_pend};
                4'h4:    m_rdata = {24'h0, m_mask};
                4'h8:    m_rdata = (m_serving ? 32'h100 : 32'h0) | 32'(m_claim);
                default: m_rdata = 32'h0;
            endcase
        end
        if (m_req_src >= 0) begin
            if (int_ack_i) begin
                m_serving = 1'b1;
                m_claim   = m_req_src;
                m_req_src = -1;
            end else if (!(np[m_req_src] && nm[m_req_src])) begin
                m_req_src = -1;
            end
        end else if (m_serving) begin
            if (int_done_i) m_serving = 1'b0;
        end else begin
            for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) m_req_src = i;
        end
        m_pend = np;
        m_mask = nm;
    endtask

    task automatic step();
        logic [7:0] exp_flag;
        model_edge();
        @(posedge clk);
        #1;
        exp_flag = (m_req_src >= 0) ? 8'(1 << m_req_src) : 8'h0;
        check("int_req_o", 32'(int_req_o), 32'(m_req_src >= 0));
        check("int_flag_o", 32'(int_flag_o), 32'(exp_flag));
        check("bus_rdata_o", bus_rdata_o, m_rdata);
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        bus_wr_en_i = 1'b1; bus_addr_i = addr; bus_wdata_i = data;
        step();
        bus_wr_en_i = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] addr);
        bus_rd_en_i = 1'b1; bus_addr_i = addr;
        step();
        bus_rd_en_i = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack_i = 1'b1; step(); int_ack_i = 1'b0;
    endtask

    task automatic pulse_done();
        int_done_i = 1'b1; step(); int_done_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_src_i = 8'h0; bus_wr_en_i = 1'b0; bus_rd_en_i = 1'b0;
        bus_addr_i = 4'h0; bus_wdata_i = 32'h0; int_ack_i = 1'b0; int_done_i = 1'b0;

        // Reset, then read all registers
        step(); step();
        rst_n = 1'b1;
        check("rst_req", 32'(int_req_o), 32'h0);
        check("rst_flag", 32'(int_flag_o), 32'h0);
        bus_read(4'h0); check("rst_pend", bus_rdata_o, 32'h0);
        bus_read(4'h4); check("rst_mask", bus_rdata_o, 32'h0);
        bus_read(4'h8); check("rst_claim", bus_rdata_o, 32'h0);

        // Masked source stays pending without a request
        irq_src_i = 8'h04; step(); irq_src_i = 8'h00; step();
        bus_read(4'h0); check("masked_pend", bus_rdata_o, 32'h04);
        check("masked_noreq", 32'(int_req_o), 32'h0);
        bus_write(4'h4, 32'h04);
        check("unmask_wait", 32'(int_req_o), 32'h0);
        step();
        check("unmask_req", 32'(int_req_o), 32'h1);
        check("unmask_flag", 32'(int_flag_o), 32'h04);
        pulse_ack(); pulse_done();

        // Priority and full handshake
        bus_write(4'h4, 32'hFF);
        irq_src_i = 8'h90; step(); irq_src_i = 8'h00; step();
        check("prio_flag", 32'(int_flag_o), 32'h10);
        pulse_ack();
        check("ack_drop_req", 32'(int_req_o), 32'h0);
        bus_read(4'h8); check("claim_busy", bus_rdata_o, 32'h104);
        bus_read(4'h0); check("pend_after_ack", bus_rdata_o, 32'h80);
        pulse_done();
        step();
        check("rearb_flag", 32'(int_flag_o), 32'h80);
        pulse_ack(); pulse_done();

        // Withdrawal by masking the granted source
        irq_src_i = 8'h08; step(); irq_src_i = 8'h00; step();
        check("wd_flag", 32'(int_flag_o), 32'h08);
        bus_write(4'h4, 32'hF7);
        check("wd_req", 32'(int_req_o), 32'h0);
        check("wd_flag0", 32'(int_flag_o), 32'h0);
        bus_read(4'h0); check("wd_pend", bus_rdata_o, 32'h08);
        bus_write(4'h0, 32'hFF);
        bus_write(4'h4, 32'hFF);

        // Set beats W1C clear on a held line
        irq_src_i = 8'h02; step(); step();
        bus_write(4'h0, 32'h02);
        bus_read(4'h0); check("set_wins", bus_rdata_o, 32'h02);
        pulse_ack();
        bus_read(4'h0); check("set_wins_ack", bus_rdata_o, 32'h02);
        pulse_done();
        irq_src_i = 8'h00;
        bus_write(4'h0, 32'h02);
        step(); step();

        // Reset in the middle of service
        irq_src_i = 8'h20; step(); irq_src_i = 8'h00; step();
        pulse_ack();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("midrst_req", 32'(int_req_o), 32'h0);
        bus_read(4'h8); check("midrst_claim", bus_rdata_o, 32'h0);
        pulse_done();
        check("midrst_done", 32'(int_req_o), 32'h0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            irq_src_i   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            bus_wr_en_i = ($urandom_range(0, 7) == 0);
            bus_rd_en_i = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0:       bus_addr_i = 4'h0;
                1:       bus_addr_i = 4'h4;
                2:       bus_addr_i = 4'h8;
                3:       bus_addr_i = 4'hC;
                default: bus_addr_i = 4'($urandom);
            endcase
            bus_wdata_i = $urandom;
            int_ack_i   = ($urandom_range(0, 2) == 0);
            int_done_i  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
